// File: rtl/mbox_pkg.sv
// Shared sizing and state types for the WB<->SPI mailbox slot scheduler,
// common to the scheduler, the mailbox RAM and the WB/SPI front ends.
package mbox_pkg;

  localparam int SLOTS  = 16;
  localparam int AW     = $clog2(SLOTS);
  localparam int DW     = 41;
  localparam int RW_BIT = DW - 1;

  typedef enum logic [1:0] {FREE, QUEUED, ISSUED, DONE} slot_state_e;

  typedef enum logic [1:0] {R_IDLE, R_RD, R_HOLD} rsp_state_e;

endpackage

// File: rtl/mbox_tag_fifo.sv
// Synchronous tag FIFO used as the in-order SPI issue queue.
// The head reads as zero while empty so the issue tag never floats.
module mbox_tag_fifo
  import mbox_pkg::*;
#(
  parameter int DEPTH = SLOTS,
  parameter int W     = AW
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          pop_ok;

  assign empty  = (count == '0);
  assign pop_ok = pop && !empty;
  assign head   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Only one entry can exist per busy slot, so push never meets a full queue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mbox_slot_scheduler.sv
// Slot allocator, in-order SPI issue queue and read-response engine for the
// 16-entry mailbox RAM. Define MBOX_SCHED_ERR_CHECK_EN for the sticky err_o flag.
module mbox_slot_scheduler #(
  parameter int SLOTS = mbox_pkg::SLOTS,
  parameter int AW    = mbox_pkg::AW,
  parameter int DW    = mbox_pkg::DW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb_req_valid,
  input  logic [DW-1:0]    wb_req_cmd,
  output logic             wb_req_ready,
  output logic [AW-1:0]    wb_req_tag,
  output logic             ram_we,
  output logic [AW-1:0]    ram_waddr,
  output logic [DW-1:0]    ram_wdata,
  output logic [AW-1:0]    ram_raddr,
  input  logic [DW-1:0]    ram_rdata,
  output logic             spi_issue_valid,
  output logic [AW-1:0]    spi_issue_tag,
  input  logic             spi_issue_ready,
  input  logic             spi_done_valid,
  input  logic [AW-1:0]    spi_done_tag,
  output logic             wb_rsp_valid,
  output logic [AW-1:0]    wb_rsp_tag,
  output logic [DW-1:0]    wb_rsp_data,
  input  logic             wb_rsp_ready,
  output logic [SLOTS-1:0] busy_mask,
  output logic             full,
  output logic             empty
`ifdef MBOX_SCHED_ERR_CHECK_EN
  ,
  output logic             err_o,
  input  logic             err_clr
`endif
);

  import mbox_pkg::*;

  slot_state_e      slot_st [SLOTS];
  logic [SLOTS-1:0] slot_rw;
  rsp_state_e       rsp_st;
  logic [AW-1:0]    rsp_tag_q;

  logic [AW-1:0]    free_idx;
  logic [AW-1:0]    done_idx;
  logic             any_done;
  logic             req_acc;
  logic             issue_acc;
  logic             done_ok;
  logic             rsp_acc;
  logic [AW-1:0]    fifo_head;
  logic             fifo_empty;

  // Lowest-index FREE and DONE slots, scanned from the top so index 0 wins.
  always_comb begin
    free_idx = '0;
    done_idx = '0;
    any_done = 1'b0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (slot_st[i] == FREE) begin
        free_idx = AW'(i);
      end
      if (slot_st[i] == DONE) begin
        done_idx = AW'(i);
        any_done = 1'b1;
      end
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < SLOTS; i++) begin
      busy_mask[i] = (slot_st[i] != FREE);
    end
  end

  assign full         = &busy_mask;
  assign empty        = ~|busy_mask;
  assign wb_req_ready = !full;
  assign wb_req_tag   = free_idx;
  assign req_acc      = wb_req_valid && wb_req_ready;

  assign ram_we    = req_acc;
  assign ram_waddr = free_idx;
  assign ram_wdata = req_acc ? wb_req_cmd : '0;

  assign spi_issue_valid = !fifo_empty;
  assign spi_issue_tag   = fifo_head;
  assign issue_acc       = spi_issue_valid && spi_issue_ready;
  assign done_ok         = spi_done_valid && (slot_st[spi_done_tag] == ISSUED);
  assign rsp_acc         = wb_rsp_valid && wb_rsp_ready;

  // The RAM sees the address during the idle cycle so data is ready in R_RD.
  assign ram_raddr  = (rsp_st == R_IDLE) ? done_idx : rsp_tag_q;
  assign wb_rsp_tag = rsp_tag_q;

  mbox_tag_fifo #(
    .DEPTH (SLOTS),
    .W     (AW)
  ) u_issue_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (req_acc),
    .push_data (free_idx),
    .pop       (issue_acc),
    .head      (fifo_head),
    .empty     (fifo_empty)
  );

  // Legal traffic never targets the same slot with two events in one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SLOTS; i++) begin
        slot_st[i] <= FREE;
      end
      slot_rw <= '0;
    end else begin
      if (req_acc) begin
        slot_st[free_idx] <= QUEUED;
        slot_rw[free_idx] <= wb_req_cmd[DW-1];
      end
      if (issue_acc) begin
        slot_st[fifo_head] <= ISSUED;
      end
      if (done_ok) begin
        slot_st[spi_done_tag] <= slot_rw[spi_done_tag] ? DONE : FREE;
      end
      if (rsp_acc) begin
        slot_st[rsp_tag_q] <= FREE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_st       <= R_IDLE;
      rsp_tag_q    <= '0;
      wb_rsp_data  <= '0;
      wb_rsp_valid <= 1'b0;
    end else begin
      case (rsp_st)
        R_IDLE: begin
          if (any_done) begin
            rsp_tag_q <= done_idx;
            rsp_st    <= R_RD;
          end
        end
        R_RD: begin
          wb_rsp_data  <= ram_rdata;
          wb_rsp_valid <= 1'b1;
          rsp_st       <= R_HOLD;
        end
        R_HOLD: begin
          if (wb_rsp_ready) begin
            wb_rsp_valid <= 1'b0;
            rsp_st       <= R_IDLE;
          end
        end
        default: rsp_st <= R_IDLE;
      endcase
    end
  end

`ifdef MBOX_SCHED_ERR_CHECK_EN
  // A new error outranks a clear arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_o <= 1'b0;
    end else if ((spi_done_valid && !done_ok) || (wb_rsp_ready && !wb_rsp_valid)) begin
      err_o <= 1'b1;
    end else if (err_clr) begin
      err_o <= 1'b0;
    end
  end
`endif

endmodule

// File: doc/mbox_slot_scheduler.md
Name: mbox_slot_scheduler

Overview:
- Single-clock controller for the 16-entry, 41-bit WB↔SPI mailbox RAM.
- Allocates free slots to Wishbone requests and writes each command into the RAM.
- Issues queued slots to the SPI engine in strict arrival order and tracks completion.
- Returns read results to the Wishbone side and frees slots, replacing per-entry busy-bit handshaking inside the RAM.

Parameters:
SLOTS, 16, number of mailbox slots (power of 2)
AW, 4, slot tag width, log2(SLOTS)
DW, 41, command word width; bit DW-1 = 1 read, 0 write

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
wb_req_valid  in  1  WB command offered
wb_req_cmd  in  DW  command word
wb_req_ready  out  1  slot available; accept when valid&ready
wb_req_tag  out  AW  slot to be allocated this cycle (lowest free index)
ram_we  out  1  RAM write strobe
ram_waddr  out  AW  RAM write address
ram_wdata  out  DW  RAM write data
ram_raddr  out  AW  RAM read address
ram_rdata  in  DW  RAM read data, 1-cycle latency
spi_issue_valid  out  1  head-of-queue slot ready for SPI
spi_issue_tag  out  AW  slot tag issued
spi_issue_ready  in  1  SPI takes the slot
spi_done_valid  in  1  SPI finished a slot (read data already in RAM)
spi_done_tag  in  AW  finished slot
wb_rsp_valid  out  1  read response available
wb_rsp_tag  out  AW  slot of the response
wb_rsp_data  out  DW  read result
wb_rsp_ready  in  1  WB takes the response
busy_mask  out  SLOTS  per-slot non-FREE flags
full  out  1  no FREE slot
empty  out  1  all slots FREE

Behaviour:
- Per-slot state: FREE, QUEUED, ISSUED, DONE. A per-slot rw bit is captured from wb_req_cmd[DW-1] at allocation.
- Reset: all slots FREE; issue FIFO empty; response FSM in R_IDLE. All outputs 0 except wb_req_ready=1 and empty=1.
- Allocation:
  - wb_req_ready = !full (combinational).
  - On accept, the same cycle drives ram_we=1, ram_waddr=tag, ram_wdata=cmd.
  - Next edge: slot becomes QUEUED and the tag is pushed to the issue FIFO.
- Issue FIFO:
  - Depth SLOTS; cannot overflow because only one entry exists per non-FREE slot.
  - spi_issue_valid = FIFO non-empty; spi_issue_tag = FIFO head.
  - On valid&ready: pop, slot becomes ISSUED.
  - A tag accepted at cycle N is visible at the head at N+1 at the earliest.
- Completion (spi_done_valid with slot ISSUED):
  - rw=0 → FREE next edge.
  - rw=1 → DONE.
  - Done on a non-ISSUED slot is ignored.
- Response FSM:
  - R_IDLE: if any slot is DONE, pick the lowest index, drive ram_raddr, go to R_RD.
  - R_RD: capture ram_rdata into wb_rsp_data, go to R_HOLD.
  - R_HOLD: wb_rsp_valid=1; data and tag held stable until wb_rsp_ready. On handshake, slot becomes FREE and the FSM returns to R_IDLE. This gives 3-cycle minimum done→rsp handshake latency.
- Simultaneous events:
  - A slot freed in cycle N is not reallocatable until N+1; allocation uses registered state.
  - Alloc, issue, done and response-free on different slots in one cycle all take effect.
  - Same-slot conflicts cannot occur legally.
- full/empty/busy_mask are registered-state derived, so they are combinational from slot state.
- Reset mid-operation drops all in-flight slots without a response. rst_n is sampled only on clk.

Optional Feature:
- Macro MBOX_SCHED_ERR_CHECK_EN.
- When defined, adds ports err_o (out 1, sticky) and err_clr (in 1).
- err_o sets on either of:
  - spi_done on a slot not ISSUED
  - wb_rsp_ready asserted while wb_rsp_valid=0
- err_o clears on err_clr or reset; set wins over clear in the same cycle.
- When undefined: ports absent; illegal events are silently ignored.

Decomposition:
- Package mbox_pkg holds:
  - slot-state enum (FREE/QUEUED/ISSUED/DONE)
  - response FSM enum (R_IDLE/R_RD/R_HOLD)
  - DW, RW_BIT = DW-1, SLOTS and AW constants, shared with the RAM and WB/SPI interfaces
- One sub-module: mbox_tag_fifo, a synchronous tag FIFO (SLOTS deep, AW wide) used as the issue queue.
- Lowest-index priority encoders stay inline.

Test Plan:
- Reset, then one write cmd 0x0_0000_00AB → tag 0, ram_we with data 0x0AB, issue tag 0; spi_done tag 0 → busy_mask=0, empty=1, no wb_rsp.
- Read cmd with bit40=1 → tag 0 issued. Preload RAM[0]=0x1_1234_5678, spi_done tag 0 → wb_rsp_valid 3 cycles later, data 0x1_1234_5678, tag 0. Hold wb_rsp_ready=0 for 5 cycles → outputs stable; ready=1 → slot freed.
- 16 back-to-back requests → tags 0..15 in order, full=1, wb_req_ready=0 on 17th. Complete tag 5 → next request gets tag 5 one cycle after the free.
- spi_issue_ready held low while tags 3, 7, 1 are allocated (in that order) → issue order 3, 7, 1 exactly.
- Reads done on tags 9 and 2 in the same cycle → responses tag 2 then tag 9. Reset asserted during R_HOLD → wb_rsp_valid=0, empty=1 next cycle.
- With MBOX_SCHED_ERR_CHECK_EN: spi_done tag 4 while slot 4 FREE → err_o=1 next cycle, state unchanged; err_clr → err_o=0.
